// File: rtl/matrix_tanh_grad.sv
// Element-wise tanh backward pass: G = dY * (1 - Y^2) in signed fixed point.
// One element per cycle through a two-stage pipeline over a captured copy of Y/dY.
module matrix_tanh_grad #(
    parameter int H           = 8,
    parameter int W           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [H*W*DATA_WIDTH-1:0]    y,
    input  logic [H*W*DATA_WIDTH-1:0]    dy,
    output logic [H*W*DATA_WIDTH-1:0]    g,
    output logic                         busy,
    output logic                         done
);
    // state | meaning
    // IDLE  | waiting for start; g holds the last results
    // RUN   | issuing element idx into stage 1, one per cycle
    // DRAIN | last element in stage 2; written on leaving this state
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int N  = H * W;
    localparam int DW = DATA_WIDTH;
    localparam int MW = 2 * DATA_WIDTH;
    localparam int PW = 3 * DATA_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]        LAST    = IW'(N - 1);
    localparam logic signed [MW-1:0] ONE     = MW'(1) << FRACT_WIDTH;
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                   state_q, state_d;
    logic [N*DW-1:0]          y_q, dy_q, g_q;
    logic [IW-1:0]            idx_q;
    logic                     done_q;
    logic                     s1_valid_q;
    logic [IW-1:0]            s1_idx_q;
    logic signed [DW-1:0]     s1_dy_q;
    logic signed [MW-1:0]     s1_t_q;

    logic                     capture, issue;
    logic signed [DW-1:0]     y_k, dy_k;
    logic signed [MW-1:0]     ysq, t_d;
    logic signed [PW-1:0]     prod, p;
    logic [DW-1:0]            sat_d;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (idx_q == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (s1_valid_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: t = 1 - y^2, kept at double width so large |y| stays exact.
    always_comb begin
        y_k  = y_q[int'(idx_q)*DW +: DW];
        dy_k = dy_q[int'(idx_q)*DW +: DW];
        ysq  = (MW'(y_k) * MW'(y_k)) >>> FRACT_WIDTH;
        t_d  = ONE - ysq;
    end

    // Stage 2: scale by dy, floor-shift, then clamp to the element range.
    always_comb begin
        prod = PW'(s1_dy_q) * PW'(s1_t_q);
        p    = prod >>> FRACT_WIDTH;
        if (p > SAT_MAX)      sat_d = {1'b0, {(DW-1){1'b1}}};
        else if (p < SAT_MIN) sat_d = {1'b1, {(DW-1){1'b0}}};
        else                  sat_d = p[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            y_q        <= '0;
            dy_q       <= '0;
            g_q        <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_dy_q    <= '0;
            s1_t_q     <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_q == DRAIN) && s1_valid_q;
            s1_valid_q <= issue;
            if (capture) begin
                y_q   <= y;
                dy_q  <= dy;
                idx_q <= '0;
            end else if (issue) begin
                idx_q <= idx_q + 1'b1;
            end
            if (issue) begin
                s1_idx_q <= idx_q;
                s1_dy_q  <= dy_k;
                s1_t_q   <= t_d;
            end
            if (s1_valid_q) g_q[int'(s1_idx_q)*DW +: DW] <= sat_d;
        end
    end

    assign g    = g_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule
